// File: rtl/multi_mac_stream.sv
// multi_mac_stream: N-channel streaming signed dot-product engine with shared B operand and valid/ready framing
module multi_mac_stream #(
  parameter int N       = 5,
  parameter int WIDTH   = 16,
  parameter int K_MAX   = 16,
  parameter int KW      = $clog2(K_MAX),
  parameter int M_WIDTH = 2*WIDTH+KW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KW-1:0]        len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*M_WIDTH-1:0] C,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
  state_t state_q, state_d;
  logic [KW:0] len_q, len_d, cnt_q, cnt_d, eff;
  logic [N*2*WIDTH-1:0] prod_q, prod_d;
  logic [N*M_WIDTH-1:0] acc_q, acc_d, c_q, c_d;
  logic pv_q, pv_d, pf_q, pf_d, ov_q, ov_d, accept;
  assign in_ready  = !rst && (state_q == IDLE || state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign busy      = state_q != IDLE;
  assign out_valid = ov_q;
  assign C         = c_q;
  assign eff       = len == '0 ? (KW+1)'(K_MAX) : {1'b0, len};
  assign pv_d      = accept;
  assign pf_d      = accept && state_q == IDLE;
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [2*WIDTH-1:0] p;
    logic [M_WIDTH-1:0] e, a;
    assign p = $signed({{WIDTH{A[WIDTH*i+WIDTH-1]}}, A[WIDTH*i +: WIDTH]}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    assign prod_d[2*WIDTH*i +: 2*WIDTH] = p;
    assign e = {{(M_WIDTH-2*WIDTH){prod_q[2*WIDTH*(i+1)-1]}}, prod_q[2*WIDTH*i +: 2*WIDTH]};
    assign a = acc_q[M_WIDTH*i +: M_WIDTH];
    assign acc_d[M_WIDTH*i +: M_WIDTH] = pv_q ? (pf_q ? e : a + e) : a;
  end
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (accept) begin
        len_d   = eff;
        cnt_d   = (KW+1)'(1);
        state_d = eff == (KW+1)'(1) ? DRAIN : ACCUM;
      end
      ACCUM: if (accept) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_d == len_q ? DRAIN : ACCUM;
      end
      DRAIN: if (!pv_q) begin
        c_d     = acc_q;
        ov_d    = 1'b1;
        state_d = HOLD;
      end
      default: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      pv_q    <= 1'b0;
      pf_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      pv_q    <= pv_d;
      pf_q    <= pf_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_multi_mac_stream.sv
// tb_multi_mac_stream: scoreboard bench for multi_mac_stream with directed frames
module tb_multi_mac_stream;
  localparam int N = 5, W = 16, KW = 4, MW = 36;
  typedef logic [N*MW-1:0] vec_t;
  logic clk = 1'b0, rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [KW-1:0] len;
  logic [N*W-1:0] A;
  logic [W-1:0] B;
  vec_t C, c_hold;
  int checks = 0, errors = 0;
  vec_t exp_q[$];
  always #5 clk = ~clk;
  multi_mac_stream #(.N(N), .WIDTH(W), .K_MAX(16)) dut (
    .clk(clk), .rst(rst), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .C(C), .busy(busy)
  );
  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [N*W-1:0] rep(input logic [W-1:0] x);
    return {N{x}};
  endfunction
  always @(negedge clk)
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected no output", C);
      end else chk("result", C, exp_q.pop_front());
    end
  task automatic beat(input logic [N*W-1:0] a, input logic [W-1:0] b);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_beat", vec_t'(in_ready), vec_t'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, vec_t'(n), vec_t'(3));
  endtask
  task automatic finish_frame(input string name);
    wait_out(name);
    @(posedge clk);
    #1;
    chk("busy_idle", vec_t'(busy), vec_t'(0));
    chk("out_valid_clear", vec_t'(out_valid), vec_t'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    len = '0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", vec_t'(in_ready), vec_t'(0));
    chk("rst_busy", vec_t'(busy), vec_t'(0));
    chk("rst_out_valid", vec_t'(out_valid), vec_t'(0));
    chk("rst_c", C, vec_t'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    len = 4'd3;
    exp_q.push_back({N{36'd24}});
    beat(rep(16'd2), 16'd3);
    beat(rep(16'd2), 16'd4);
    beat(rep(16'd2), 16'd5);
    finish_frame("latency_len3");
    len = 4'd1;
    exp_q.push_back({144'd0, 36'hF_FFFF_8001});
    beat({64'd0, 16'hFFFF}, 16'h7FFF);
    finish_frame("latency_len1");
    len = 4'd0;
    exp_q.push_back({N{36'h4_0000_0000}});
    for (int i = 0; i < 16; i++) beat(rep(16'h8000), 16'h8000);
    finish_frame("latency_len16");
    len = 4'd2;
    exp_q.push_back({36'd1, -36'sd2, -36'sd5, -36'sd8, -36'sd11});
    beat({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 16'd3);
    len = 4'd5;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    beat(rep(16'd7), 16'hFFFE);
    wait_out("latency_bubbles");
    c_hold = C;
    repeat (5) begin
      @(posedge clk);
      #1;
      A = rep(16'd9);
      B = 16'd9;
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_in_ready", vec_t'(in_ready), vec_t'(0));
      chk("hold_out_valid", vec_t'(out_valid), vec_t'(1));
      chk("hold_c_stable", C, c_hold);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_idle", vec_t'(busy), vec_t'(0));
    len = 4'd4;
    beat(rep(16'd1), 16'd9);
    beat(rep(16'd1), 16'd9);
    A = rep(16'd1);
    B = 16'd9;
    in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_blocks_ready", vec_t'(in_ready), vec_t'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", vec_t'(busy), vec_t'(0));
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_out", vec_t'(out_valid), vec_t'(0));
    len = 4'd1;
    exp_q.push_back({N{36'd5}});
    beat(rep(16'd1), 16'd5);
    finish_frame("latency_after_abort");
    chk("queue_empty", vec_t'(exp_q.size()), vec_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
